// File: rtl/rr_mux4_arbiter.sv
// Round-robin arbiter and select sequencer for a shared 4:1 mux with
// valid/ready output handshake and a per-grant burst cap.
module rr_mux4_arbiter #(
    parameter int unsigned W         = 8,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [3:0]   req,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    input  logic [W-1:0] d,
    input  logic         out_ready,
    output logic [3:0]   gnt,
    output logic [1:0]   sin,
    output logic [W-1:0] f,
    output logic         out_valid,
    output logic         busy
);

    localparam int unsigned CW   = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] LAST = CW'(MAX_BURST - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t        state_q;
    logic [3:0]    gnt_q;
    logic [1:0]    sin_q;
    logic [1:0]    ptr_q;
    logic [CW-1:0] cnt_q;

    logic          req_sel;
    logic          beat;
    logic          release_now;
    logic          arbitrate;
    logic [1:0]    ptr_d;
    logic [1:0]    cand;
    logic          pick_found;
    logic [1:0]    pick_idx;

    assign busy      = (state_q == S_GRANT);
    assign gnt       = gnt_q;
    assign sin       = sin_q;
    assign out_valid = busy & req_sel;

    // Handshake, release detection and round-robin search from the effective pointer
    always_comb begin
        req_sel     = req[sin_q];
        beat        = busy & req_sel & out_ready;
        release_now = busy & (~req_sel | (beat & (cnt_q == LAST)));
        arbitrate   = ~busy | release_now;
        ptr_d       = release_now ? (sin_q + 2'd1) : ptr_q;
        pick_found  = 1'b0;
        pick_idx    = ptr_d;
        cand        = ptr_d;
        // Walk from farthest to nearest so the nearest requester wins
        for (int k = 3; k >= 0; k--) begin
            cand = ptr_d + 2'(k);
            if (req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Grant FSM: arbitrate when idle or releasing, otherwise count accepted beats
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            gnt_q   <= 4'd0;
            sin_q   <= 2'd0;
            ptr_q   <= 2'd0;
            cnt_q   <= '0;
        end else if (arbitrate) begin
            ptr_q <= ptr_d;
            cnt_q <= '0;
            if (pick_found) begin
                state_q <= S_GRANT;
                gnt_q   <= 4'(4'd1 << pick_idx);
                sin_q   <= pick_idx;
            end else begin
                state_q <= S_IDLE;
                gnt_q   <= 4'd0;
            end
        end else if (beat) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    // Output mux, forced to zero while idle
    always_comb begin
        f = '0;
        if (busy) begin
            unique case (sin_q)
                2'd0: f = a;
                2'd1: f = b;
                2'd2: f = c;
                2'd3: f = d;
                default: f = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_mux4_arbiter.sv
// Self-checking bench for rr_mux4_arbiter: directed scenarios plus random
// traffic compared every cycle against a behavioural round-robin model.
module tb_rr_mux4_arbiter;

    localparam int unsigned W  = 8;
    localparam int unsigned MB = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   req;
    logic [W-1:0] dv [4];
    logic [W-1:0] a, b, c, d;
    logic         out_ready;
    logic [3:0]   gnt;
    logic [1:0]   sin;
    logic [W-1:0] f;
    logic         out_valid;
    logic         busy;

    assign a = dv[0];
    assign b = dv[1];
    assign c = dv[2];
    assign d = dv[3];

    rr_mux4_arbiter #(.W(W), .MAX_BURST(MB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .out_ready (out_ready),
        .gnt       (gnt),
        .sin       (sin),
        .f         (f),
        .out_valid (out_valid),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model: who owns the mux, where the next search starts, beats taken
    bit m_busy  = 1'b0;
    int m_owner = 0;
    int m_ptr   = 0;
    int m_beats = 0;

    // Observations from the most recent cycle
    int obs_sin;
    bit obs_busy;
    bit obs_valid;
    bit obs_beat;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Model step at a rising edge, from the spec's round-robin rules
    task automatic model_edge();
        bit valid, acc, rel;
        int start;
        bit found;
        if (!rst_n) begin
            m_busy = 0; m_owner = 0; m_ptr = 0; m_beats = 0;
            return;
        end
        valid = m_busy && req[m_owner];
        acc   = valid && out_ready;
        rel   = m_busy && (!req[m_owner] || (acc && m_beats == MB - 1));
        if (!m_busy || rel) begin
            start = rel ? (m_owner + 1) % 4 : m_ptr;
            m_ptr = start;
            found = 0;
            for (int k = 0; k < 4 && !found; k++) begin
                if (req[(start + k) % 4]) begin
                    found   = 1;
                    m_owner = (start + k) % 4;
                end
            end
            m_busy  = found;
            m_beats = 0;
        end else if (acc) begin
            m_beats++;
        end
    endtask

    // One clock: compare all outputs to the model, then advance both
    task automatic cycle();
        logic [3:0]   eg;
        logic [W-1:0] ef;
        logic         ev;
        #1;
        eg = m_busy ? 4'(4'd1 << m_owner) : 4'd0;
        ev = m_busy && req[m_owner];
        ef = m_busy ? dv[m_owner] : '0;
        check("gnt",       32'(gnt),       32'(eg));
        check("sin",       32'(sin),       32'(m_owner));
        check("busy",      32'(busy),      32'(m_busy));
        check("out_valid", 32'(out_valid), 32'(ev));
        check("f",         32'(f),         32'(ef));
        check("ptr",       32'(dut.ptr_q), 32'(m_ptr));
        check("cnt",       32'(dut.cnt_q), 32'(m_beats));
        obs_sin   = int'(sin);
        obs_busy  = busy;
        obs_valid = out_valid;
        obs_beat  = out_valid & out_ready;
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic do_reset(input logic [3:0] r);
        rst_n     = 1'b0;
        req       = r;
        out_ready = 1'b1;
        cycle();
        cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout t=%0t", $time);
        $fatal(1, "bench timeout");
    end

    initial begin
        int nb, nr;
        rst_n     = 1'b0;
        req       = 4'd0;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) dv[i] = W'(8'hA0 + i);
        @(negedge clk);

        // Reset with all requesting, then first grant
        do_reset(4'hF);
        check("rst_gnt",  32'(gnt),  32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_f",    32'(f),    32'h0);
        cycle();
        check("first_gnt", 32'(gnt), 32'h1);
        check("first_sin", 32'(sin), 32'h0);

        // Rotation: 4 beats each, order 0,1,2,3,0, no idle cycles
        for (int j = 0; j < 26; j++) begin
            cycle();
            if (j < 20) begin
                check("rot_sin",  32'(obs_sin),  32'((j / 4) % 4));
                check("rot_beat", 32'(obs_beat), 32'h1);
            end
        end

        // Reset during grant 2 with two beats taken
        check("mid_sin", 32'(sin),       32'h2);
        check("mid_cnt", 32'(dut.cnt_q), 32'h2);
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        req   = 4'h0;
        check("mid_busy", 32'(busy),      32'h0);
        check("mid_ptr",  32'(dut.ptr_q), 32'h0);
        for (int j = 0; j < 4; j++) begin
            cycle();
            check("idle_busy",  32'(obs_busy),  32'h0);
            check("idle_valid", 32'(obs_valid), 32'h0);
        end

        // Drop-release: requester 0 drops after 2 beats, 2 takes over
        do_reset(4'b0101);
        cycle();
        cycle();
        cycle();
        req = 4'b0100;
        cycle();
        check("drop_gnt", 32'(gnt),       32'h4);
        check("drop_ptr", 32'(dut.ptr_q), 32'h1);
        check("drop_cnt", 32'(dut.cnt_q), 32'h0);
        cycle();

        // Single requester: every ready cycle is a beat, across re-grants
        do_reset(4'b1000);
        cycle();
        nb = 0;
        nr = 0;
        for (int j = 0; j < 24; j++) begin
            out_ready = 1'($urandom_range(0, 1));
            cycle();
            nb += int'(obs_beat);
            nr += int'(out_ready);
            check("single_sin", 32'(obs_sin), 32'h3);
        end
        check("single_beats", 32'(nb), 32'(nr));

        // Stall on grant 1, then exactly 3 remaining beats before rotation
        do_reset(4'b0110);
        cycle();
        cycle();
        out_ready = 1'b0;
        for (int j = 0; j < 5; j++) begin
            cycle();
            check("stall_valid", 32'(obs_valid),   32'h1);
            check("stall_sin",   32'(obs_sin),     32'h1);
            check("stall_cnt",   32'(dut.cnt_q),   32'h1);
        end
        out_ready = 1'b1;
        for (int j = 0; j < 3; j++) begin
            cycle();
            check("resume_sin",  32'(obs_sin),  32'h1);
            check("resume_beat", 32'(obs_beat), 32'h1);
        end
        cycle();
        check("rotate_sin", 32'(obs_sin), 32'h2);

        // Random traffic against the model
        for (int j = 0; j < 3000; j++) begin
            rst_n     = ($urandom_range(0, 63) != 0);
            req       = 4'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) begin
                for (int i = 0; i < 4; i++) dv[i] = W'($urandom);
            end
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rr_mux4_arbiter.md
# rr_mux4_arbiter

Round-robin arbiter and sequencer for a shared 4:1 multiplexer. Four requesters present data words and request lines; the block grants one requester at a time and drives the mux select. It forwards the selected word downstream under a valid/ready handshake and caps each grant at a burst limit so no requester starves. It sits directly in front of the 4:1 mux datapath and owns its select input.

## Interface
- `W`, default 8: data width of each requester word and of the output.
- `MAX_BURST`, default 4: maximum number of accepted beats per grant (legal range 1..15).

- `clk` input 1: single clock; all state updates on rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `req` input 4: request per requester; bit i belongs to requester i (a=0, b=1, c=2, d=3).
- `a`, `b`, `c`, `d` input W: requester data words.
- `out_ready` input 1: downstream can accept a beat this cycle.
- `gnt` output 4: one-hot registered grant, or 0 when idle.
- `sin` output 2: registered mux select, equal to the index of the granted requester.
- `f` output W: the selected word, `f = {a,b,c,d}[sin]`, combinational from `sin`; 0 when idle.
- `out_valid` output 1: `busy & req[sin]`.
- `busy` output 1: a grant is active.

## Operation
- Two states:
  - **IDLE** (`busy=0`, `gnt=0`).
  - **GRANT** (`busy=1`, `gnt` one-hot).
- Internal registers:
  - `ptr[1:0]`: round-robin start index.
  - `cnt`: accepted beats in the current grant; width is ceil(log2(MAX_BURST+1)).
- Beat accepted: `out_valid & out_ready`.
- Release condition, evaluated in GRANT:
  - `req[sin]==0`, which is a drop-release with no beat that cycle; or
  - a beat is accepted with `cnt==MAX_BURST-1`, which is a burst-release.
- Arbitration runs in IDLE, or in GRANT on a release cycle:
  - Pick the first i with `req[i]=1`, searching `ptr, ptr+1, ptr+2, ptr+3` mod 4.
  - On a release, `ptr` used for this search is first set to `sin+1` (wrap 3→0). The search uses that updated value combinationally, in the same cycle.
- On a pick: next cycle GRANT with `gnt=1<<i`, `sin=i`, `cnt=0`, `ptr` registered as the release value.
- No pick: next cycle IDLE, `gnt=0`, `cnt=0`.
- In GRANT without release: `cnt` increments on each accepted beat; `gnt` and `sin` are held.
- Burst-release with only the same requester still requesting: the same requester is re-granted next cycle with `cnt=0`, because the search wraps back to it.
- Drop-release: that requester cannot be re-picked in the release cycle, since its `req` bit is 0.
- `req` changing on other lines during a grant has no effect until release.
- `f` is the plain 4:1 mux of the data inputs by `sin`, forced to 0 when `busy=0`.

## Timing
- Reset (`rst_n=0` at a rising edge): `busy=0`, `gnt=0`, `sin=0`, `ptr=0`, `cnt=0`. As a result `f=0` and `out_valid=0`.
- Reset mid-grant aborts the grant immediately at that edge. No beat is counted in that cycle.
- Grant latency: `req` seen in IDLE at edge N gives `gnt` and `out_valid` from edge N+1.
- Release to next grant: zero-bubble. A release at edge N with another request pending gives the new `gnt` at edge N+1.
- Per grant: at most MAX_BURST beats, then forced rotation.
- Worst-case wait for a continuously requesting master: 3×MAX_BURST beats plus stall cycles.
- `out_ready` stalls (`out_ready=0`) hold the grant indefinitely while `req` stays high. Counting resumes on the next accepted beat.
- `out_valid` is combinational from registered `sin`/`busy` and input `req`. `f` is combinational from `sin` and the data inputs.
- No combinational path exists from `out_ready` to `gnt` or `sin`.

## Test plan
- **Reset:** hold `rst_n=0` two cycles with `req=4'hF` → `gnt=0`, `sin=0`, `busy=0`, `f=0`. Release reset → `gnt=4'b0001`, `sin=0` one cycle later.
- **Rotation:** `req=4'hF`, `out_ready=1`, `MAX_BURST=4`, `a..d=8'hA0..8'hA3`. Each grant must give exactly 4 beats, with grant order 0,1,2,3,0. `f` must match the granted word, and there must be no idle cycle between grants.
- **Drop-release:** `req=4'b0101`; requester 0 drops `req` after 2 beats → `gnt=4'b0100` next cycle, `ptr=1`, `cnt=0`.
- **Single requester burst:** `req=4'b1000` only → grant 3 for 4 beats. Re-grant 3 on the next cycle with `cnt=0`. Total beats equal the number of cycles with `out_ready=1`.
- **Stall:** grant 1 active, `out_ready=0` for 5 cycles → `gnt`, `sin`, `cnt` unchanged and `out_valid=1` throughout. After `out_ready` returns, exactly the remaining beats occur before rotation.
- **Reset mid-grant and idle:** assert `rst_n=0` during grant 2 with `cnt=2` → next cycle `busy=0`, `ptr=0`. With `req=0` the block stays IDLE, `f=0` and `out_valid=0`.
